ss_fifo: RTL and testbench
==========================

Name: ss_fifo

Overview:
- Per-channel stream FIFO feeding the DMA engine's slave-stream pop interface.
- Sources ss_readyN, wbs_dat_iN and (optionally) wbs_dat64_iN; consumes the engine's ss_xferN pop strobe.
- The upstream producer (bus write path or core) pushes 32-bit words.
- Keeps a 24-bit popped-word count (dc) for the channel status registers.

Parameters:
AW, 4, address width; FIFO depth = 2**AW words (default 16)
DCW, 24, width of popped-word counter dc

Ports:
wb_clk_i  input  1  clock; all logic on rising edge
wb_rst_i  input  1  reset, synchronous, active-low (0 = reset)
flush  input  1  synchronous clear of FIFO contents and error flag
wr_en  input  1  push strobe from producer
wr_dat  input  32  push data
wr_full  output  1  FIFO holds 2**AW words
level  output  AW+1  current word count, 0..2**AW
ss_xfer  input  1  pop strobe from DMA engine, one word per cycle
ss_ready  output  1  at least one word available
wbs_dat_i  output  32  head word, first-word-fall-through
dc  output  DCW  total words popped since reset/flush, wraps modulo 2**DCW
err  output  1  sticky: pop while empty or push while full

Behaviour:
- Reset (wb_rst_i=0 at a clock edge) sets:
  - wr_ptr=0, rd_ptr=0, level=0, dc=0, err=0;
  - hence ss_ready=0, wr_full=0.
  - wbs_dat_i is don't-care while ss_ready=0; memory contents are not reset.
- Storage: 2**AW x 32 register array. Pointers are AW bits and wrap naturally from 2**AW-1 to 0.
- Status decode from the registered level:
  - ss_ready = (level != 0); wr_full = (level == 2**AW).
  - Both are valid in the cycle after the causing edge; no combinational path from wr_en/ss_xfer.
- wbs_dat_i = mem[rd_ptr], decoded combinationally from registered state.
- Push accept = wr_en & ~wr_full. On accept: mem[wr_ptr] <= wr_dat; wr_ptr++.
- Pop accept = ss_xfer & ss_ready. On accept: rd_ptr++; dc++.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push latency: a word pushed into an empty FIFO at edge N gives ss_ready=1 and wbs_dat_i=word after edge N. There is no bubble.
- Simultaneous push+pop:
  - When 0<level<2**AW, both take effect and level is unchanged.
  - When empty, only the push takes effect; the pop is rejected.
  - When full, the push is dropped even if a pop occurs in the same cycle; only the pop takes effect.
- Errors: rejected push (wr_en & wr_full) or rejected pop (ss_xfer & ~ss_ready) sets err=1 at the next edge and state is unchanged. err holds until reset or flush.
- flush=1: next edge clears wr_ptr, rd_ptr, level, err and dc. Any push or pop in the same cycle is ignored. flush has lower priority than reset.
- Reset or flush mid-burst discards the remaining words with no further ss_ready.
- dc wraps from 2**DCW-1 to 0 silently; the wrap does not set err.

Optional Feature:
- Macro SS_FIFO_64_EN.
- When defined, adds these ports:
  - wbs_dat64_i output 32: word at rd_ptr+1 (mod depth).
  - ss_ready64 output 1: level >= 2.
  - ss_xfer64 input 1: pop two words.
- Pop-64 accept = ss_xfer64 & ss_ready64: rd_ptr += 2, dc += 2, level -= 2 (push in the same cycle makes it -1 net).
- If ss_xfer64 is not accepted it sets err with no state change.
- ss_xfer and ss_xfer64 asserted together: ss_xfer64 wins, ss_xfer is ignored and err is not set.
- When undefined: the ports are absent, and the logic and behaviour are exactly the 32-bit description above.

Test Plan:
- Reset with wb_rst_i=0 for 2 cycles, then release; push 0x11111111, 0x22222222 on consecutive cycles.
  -> ss_ready=1 one cycle after the first push, wbs_dat_i=0x11111111, level=2; pop once -> wbs_dat_i=0x22222222, dc=1.
- Push 16 words 0x0..0xF, then push 0xDEAD.
  -> wr_full=1, level=16, err=1; popping 16 returns 0x0..0xF in order, then ss_ready=0, dc=16.
- At level=5, assert wr_en and ss_xfer together for 10 cycles.
  -> level stays 5, dc=10, data order preserved; ss_xfer at level=0 -> err=1, level stays 0.
- Full FIFO: assert wr_en and ss_xfer together.
  -> pop accepted, push dropped, level=15, err=1.
- Push 3 words, then flush=1 for one cycle.
  -> level=0, ss_ready=0, dc=0, err=0; the next pushed word 0xA5A5A5A5 appears on wbs_dat_i one cycle later.
- With SS_FIFO_64_EN defined: push 0x1,0x2,0x3, then pulse ss_xfer64.
  -> before the pop: wbs_dat_i=0x1, wbs_dat64_i=0x2.
  -> after the pop: wbs_dat_i=0x3, level=1, ss_ready64=0, dc=2.
  -> a further ss_xfer64 sets err.

Source files
------------

// File: rtl/ss_fifo.sv
// ss_fifo: per-channel first-word-fall-through stream FIFO feeding the DMA slave-stream pop port.
// Define SS_FIFO_64_EN to add the dual-word pop port (wbs_dat64_i, ss_ready64, ss_xfer64).
module ss_fifo #(
    parameter int AW  = 4,
    parameter int DCW = 24
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic           flush,
    input  logic           wr_en,
    input  logic [31:0]    wr_dat,
    output logic           wr_full,
    output logic [AW:0]    level,
    input  logic           ss_xfer,
    output logic           ss_ready,
    output logic [31:0]    wbs_dat_i,
    output logic [DCW-1:0] dc,
    output logic           err
`ifdef SS_FIFO_64_EN
    ,
    output logic [31:0]    wbs_dat64_i,
    output logic           ss_ready64,
    input  logic           ss_xfer64
`endif
);

    localparam int          DEPTH      = 1 << AW;
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q,  level_d;
    logic [DCW-1:0] dc_q,     dc_d;
    logic           err_q,    err_d;

    logic           push_acc;
    logic           push_rej;
    logic [1:0]     pop_cnt;
    logic           pop_rej;
    logic           mem_we;

    // Status flags decode only registered state, so they never depend on this cycle's strobes.
    assign ss_ready  = (level_q != '0);
    assign wr_full   = (level_q == LEVEL_FULL);
    assign level     = level_q;
    assign dc        = dc_q;
    assign err       = err_q;
    assign wbs_dat_i = mem_q[rd_ptr_q];

`ifdef SS_FIFO_64_EN
    assign ss_ready64  = (level_q >= (AW+1)'(2));
    assign wbs_dat64_i = mem_q[rd_ptr_q + AW'(1)];
`endif

    // Request decode: a full FIFO drops the push even when a pop lands in the same cycle.
    always_comb begin
        push_acc = wr_en & ~wr_full;
        push_rej = wr_en & wr_full;
        pop_cnt  = 2'd0;
        pop_rej  = 1'b0;
`ifdef SS_FIFO_64_EN
        if (ss_xfer64) begin
            if (ss_ready64) begin
                pop_cnt = 2'd2;
            end else begin
                pop_rej = 1'b1;
            end
        end else if (ss_xfer) begin
            if (ss_ready) begin
                pop_cnt = 2'd1;
            end else begin
                pop_rej = 1'b1;
            end
        end
`else
        if (ss_xfer) begin
            if (ss_ready) begin
                pop_cnt = 2'd1;
            end else begin
                pop_rej = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dc_d     = dc_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            dc_d     = '0;
            err_d    = 1'b0;
        end else begin
            mem_we   = push_acc;
            wr_ptr_d = wr_ptr_q + AW'(push_acc);
            rd_ptr_d = rd_ptr_q + AW'(pop_cnt);
            dc_d     = dc_q + DCW'(pop_cnt);
            level_d  = level_q + (AW+1)'(push_acc) - (AW+1)'(pop_cnt);
            err_d    = err_q | push_rej | pop_rej;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dc_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dc_q     <= dc_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define which words are valid.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i && mem_we) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

endmodule

// File: tb/tb_ss_fifo.sv
// tb_ss_fifo: scoreboard-driven self-checking bench for ss_fifo.
// Honours SS_FIFO_64_EN to exercise the dual-word pop port.
module tb_ss_fifo;

    localparam int AW    = 4;
    localparam int DCW   = 24;
    localparam int DEPTH = 1 << AW;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic           wr_en;
    logic [31:0]    wr_dat;
    logic           wr_full;
    logic [AW:0]    level;
    logic           ss_xfer;
    logic           ss_ready;
    logic [31:0]    wbs_dat_i;
    logic [DCW-1:0] dc;
    logic           err;
`ifdef SS_FIFO_64_EN
    logic [31:0]    wbs_dat64_i;
    logic           ss_ready64;
    logic           ss_xfer64;
`endif

    int             total;
    int             bad;
    logic [31:0]    exp_q[$];
    int             mdl_level;
    logic [DCW-1:0] mdl_dc;
    logic           mdl_err;

    ss_fifo #(.AW(AW), .DCW(DCW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_dat     (wr_dat),
        .wr_full    (wr_full),
        .level      (level),
        .ss_xfer    (ss_xfer),
        .ss_ready   (ss_ready),
        .wbs_dat_i  (wbs_dat_i),
        .dc         (dc),
        .err        (err)
`ifdef SS_FIFO_64_EN
        ,
        .wbs_dat64_i(wbs_dat64_i),
        .ss_ready64 (ss_ready64),
        .ss_xfer64  (ss_xfer64)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of stimulus and advance the reference model and scoreboard.
    task automatic step(input logic we, input logic [31:0] d, input logic xf, input logic x64, input logic fl);
        bit push_ok, pop1_ok, pop2_ok;
        push_ok = !fl && we && (mdl_level < DEPTH);
        pop2_ok = !fl && x64 && (mdl_level >= 2);
        pop1_ok = !fl && xf && !x64 && (mdl_level >= 1);
        if (fl) begin
            exp_q.delete();
            mdl_level = 0;
            mdl_dc    = '0;
            mdl_err   = 1'b0;
        end else begin
            if ((we && !push_ok) || (x64 && !pop2_ok) || (xf && !x64 && !pop1_ok)) mdl_err = 1'b1;
            if (pop2_ok) begin
                void'(exp_q.pop_front());
                void'(exp_q.pop_front());
                mdl_dc    = mdl_dc + DCW'(2);
                mdl_level = mdl_level - 2;
            end
            if (pop1_ok) begin
                void'(exp_q.pop_front());
                mdl_dc    = mdl_dc + DCW'(1);
                mdl_level = mdl_level - 1;
            end
            if (push_ok) begin
                exp_q.push_back(d);
                mdl_level = mdl_level + 1;
            end
        end
        wr_en   = we;
        wr_dat  = d;
        ss_xfer = xf;
        flush   = fl;
`ifdef SS_FIFO_64_EN
        ss_xfer64 = x64;
`endif
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        ss_xfer = 1'b0;
        flush   = 1'b0;
`ifdef SS_FIFO_64_EN
        ss_xfer64 = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        mdl_level = 0;
        mdl_dc    = '0;
        mdl_err   = 1'b0;
        total++; if (level !== '0)      begin bad++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
        total++; if (ss_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", ss_ready); end
        total++; if (wr_full !== 1'b0)  begin bad++; $display("[TB] FAIL reset_full got=%b exp=0", wr_full); end
        total++; if (dc !== '0)         begin bad++; $display("[TB] FAIL reset_dc got=%0d exp=0", dc); end
        total++; if (err !== 1'b0)      begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        step(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0);
        total++; if (ss_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready got=%b exp=1", ss_ready); end
        total++; if (wbs_dat_i !== 32'h11111111) begin bad++; $display("[TB] FAIL basic_head got=%h exp=11111111", wbs_dat_i); end
        step(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 5'd2) begin bad++; $display("[TB] FAIL basic_level got=%0d exp=2", level); end
        total++; if (wbs_dat_i !== exp_q[0]) begin bad++; $display("[TB] FAIL basic_sb got=%h exp=%h", wbs_dat_i, exp_q[0]); end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++; if (wbs_dat_i !== 32'h22222222) begin bad++; $display("[TB] FAIL basic_pop_head got=%h exp=22222222", wbs_dat_i); end
        total++; if (dc !== 24'd1) begin bad++; $display("[TB] FAIL basic_dc got=%0d exp=1", dc); end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++; if (ss_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_drained got=%b exp=0", ss_ready); end
    endtask

    task automatic test_full();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        total++; if (wr_full !== 1'b1) begin bad++; $display("[TB] FAIL full_flag got=%b exp=1", wr_full); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL full_err_pre got=%b exp=0", err); end
        step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        total++; if (level !== 5'd16) begin bad++; $display("[TB] FAIL full_level got=%0d exp=16", level); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL full_err got=%b exp=1", err); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (wbs_dat_i !== 32'(i)) begin bad++; $display("[TB] FAIL full_order[%0d] got=%h exp=%h", i, wbs_dat_i, 32'(i)); end
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        total++; if (ss_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_empty got=%b exp=0", ss_ready); end
        total++; if (dc !== 24'd16) begin bad++; $display("[TB] FAIL full_dc got=%0d exp=16", dc); end
        total++; if (wr_full !== 1'b0) begin bad++; $display("[TB] FAIL full_clear got=%b exp=0", wr_full); end
    endtask

    task automatic test_simultaneous();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            total++; if (wbs_dat_i !== exp_q[0]) begin bad++; $display("[TB] FAIL simul_head[%0d] got=%h exp=%h", i, wbs_dat_i, exp_q[0]); end
            step(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);
            total++; if (level !== 5'd5) begin bad++; $display("[TB] FAIL simul_level[%0d] got=%0d exp=5", i, level); end
        end
        total++; if (dc !== 24'd10) begin bad++; $display("[TB] FAIL simul_dc got=%0d exp=10", dc); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL simul_err got=%b exp=0", err); end
        for (int i = 0; i < 5; i++) begin
            total++; if (wbs_dat_i !== exp_q[0]) begin bad++; $display("[TB] FAIL simul_drain[%0d] got=%h exp=%h", i, wbs_dat_i, exp_q[0]); end
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL underflow_err got=%b exp=1", err); end
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL underflow_level got=%0d exp=0", level); end
        total++; if (dc !== mdl_dc) begin bad++; $display("[TB] FAIL underflow_dc got=%0d exp=%0d", dc, mdl_dc); end
    endtask

    task automatic test_full_simultaneous();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBAD, 1'b1, 1'b0, 1'b0);
        total++; if (level !== 5'd15) begin bad++; $display("[TB] FAIL fullsim_level got=%0d exp=15", level); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL fullsim_err got=%b exp=1", err); end
        total++; if (dc !== 24'd1) begin bad++; $display("[TB] FAIL fullsim_dc got=%0d exp=1", dc); end
        for (int i = 0; i < DEPTH - 1; i++) begin
            total++; if (wbs_dat_i !== exp_q[0]) begin bad++; $display("[TB] FAIL fullsim_order[%0d] got=%h exp=%h", i, wbs_dat_i, exp_q[0]); end
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        total++; if (level !== 5'(mdl_level)) begin bad++; $display("[TB] FAIL fullsim_end got=%0d exp=%0d", level, mdl_level); end
    endtask

    task automatic test_empty_simultaneous();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL emptysim_level got=%0d exp=1", level); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL emptysim_err got=%b exp=1", err); end
        total++; if (dc !== 24'd0) begin bad++; $display("[TB] FAIL emptysim_dc got=%0d exp=0", dc); end
        total++; if (wbs_dat_i !== 32'h77) begin bad++; $display("[TB] FAIL emptysim_head got=%h exp=77", wbs_dat_i); end
    endtask

    task automatic test_flush();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF, 1'b1, 1'b0, 1'b1);
        total++; if (level !== 5'd0) begin bad++; $display("[TB] FAIL flush_level got=%0d exp=0", level); end
        total++; if (ss_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready got=%b exp=0", ss_ready); end
        total++; if (dc !== 24'd0) begin bad++; $display("[TB] FAIL flush_dc got=%0d exp=0", dc); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL flush_err got=%b exp=0", err); end
        step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        total++; if (wbs_dat_i !== 32'hA5A5A5A5) begin bad++; $display("[TB] FAIL flush_next got=%h exp=a5a5a5a5", wbs_dat_i); end
        total++; if (ss_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_next_ready got=%b exp=1", ss_ready); end
    endtask

`ifdef SS_FIFO_64_EN
    task automatic test_pop64();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        total++; if (wbs_dat_i !== 32'h1) begin bad++; $display("[TB] FAIL p64_head got=%h exp=1", wbs_dat_i); end
        total++; if (wbs_dat64_i !== 32'h2) begin bad++; $display("[TB] FAIL p64_head2 got=%h exp=2", wbs_dat64_i); end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        total++; if (wbs_dat_i !== 32'h3) begin bad++; $display("[TB] FAIL p64_after got=%h exp=3", wbs_dat_i); end
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL p64_level got=%0d exp=1", level); end
        total++; if (ss_ready64 !== 1'b0) begin bad++; $display("[TB] FAIL p64_ready64 got=%b exp=0", ss_ready64); end
        total++; if (dc !== 24'd2) begin bad++; $display("[TB] FAIL p64_dc got=%0d exp=2", dc); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL p64_err_pre got=%b exp=0", err); end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL p64_err got=%b exp=1", err); end
        total++; if (level !== 5'd1) begin bad++; $display("[TB] FAIL p64_hold got=%0d exp=1", level); end
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h504, 1'b1, 1'b1, 1'b0);
        total++; if (level !== 5'd3) begin bad++; $display("[TB] FAIL p64_both_level got=%0d exp=3", level); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL p64_both_err got=%b exp=0", err); end
        total++; if (wbs_dat_i !== exp_q[0]) begin bad++; $display("[TB] FAIL p64_both_head got=%h exp=%h", wbs_dat_i, exp_q[0]); end
    endtask
`endif

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_dat  = '0;
        ss_xfer = 1'b0;
`ifdef SS_FIFO_64_EN
        ss_xfer64 = 1'b0;
`endif
        test_reset();
        test_basic();
        test_full();
        test_simultaneous();
        test_full_simultaneous();
        test_empty_simultaneous();
        test_flush();
`ifdef SS_FIFO_64_EN
        test_pop64();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
